dmem_responder: RTL

Single-port data-memory responder on the core's `d_*` bus: accepts `d_rd_req`/`d_wr_req`, holds a registered word-addressed SRAM array, applies byte-enable writes and answers with one-cycle `d_rd_ready`/`d_wr_ready` pulses after a configurable number of wait states. It sits between the core's data port and on-chip data RAM and is the reference target for exercising core stall behaviour.

---
 rtl/dmem_responder.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Purpose  : Single-port data-memory responder on the core's d_* bus. It
//            accepts read and write requests, holds a word-addressed SRAM
//            array and answers each request with a one-cycle ready pulse
//            after WAIT_CYCLES wait states.
//
// Ports    : clk         in   clock, all logic on posedge
//            rst         in   synchronous active-high reset
//            d_addr      in   byte address (bits [1:0] ignored)
//            d_rd_req    in   read request, level, held until ready
//            d_wr_req    in   write request, level, held until ready
//            d_be        in   write byte enables, d_be[i] -> lane [8i+7:8i]
//            d_wr_data   in   lane-aligned write data
//            d_rd_ready  out  one-cycle read-complete pulse
//            d_wr_ready  out  one-cycle write-complete pulse
//            d_rd_data   out  full word read, valid with d_rd_ready
//            bus_err     out  sticky range error (only with DMEM_ERR_EN)
//
// Options  : DMEM_ERR_EN  when defined, adds the bus_err port and its
//                          sticky error register.
// Revision : 1.0 - initial release
// ============================================================================

module dmem_responder #(
  parameter int unsigned DEPTH       = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] d_addr,
  input  logic        d_rd_req,
  input  logic        d_wr_req,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_wr_data,
  output logic        d_rd_ready,
  output logic        d_wr_ready,
  output logic [31:0] d_rd_data
`ifdef DMEM_ERR_EN
  ,
  output logic        bus_err
`endif
);

  localparam int unsigned c_AW   = $clog2(DEPTH);
  // Byte span of the array; one bit wider than the address so that a
  // 4 GiB array would still compare correctly.
  localparam logic [32:0] c_SPAN = 33'(DEPTH) << 2;
  localparam logic [3:0]  c_WAIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;

  logic [31:0]      w_offset;
  logic             w_in_range;
  logic [c_AW-1:0]  w_idx;

  logic             w_accept;
  logic             w_accept_wr;
  logic             w_enter_ack;
  logic             w_ack_rd;
  logic [c_AW-1:0]  w_ack_idx;
  logic             w_ack_in_range;

  // Write data and byte enables are committed on the acceptance edge, so
  // only the word index, range flag and transaction type outlive it.
  logic [c_AW-1:0]  r_idx;
  logic             r_in_range;
  logic             r_is_wr;
  logic [31:0]      r_rd_data;

  logic [31:0]      r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Address decode on the live bus
  // --------------------------------------------------------------------------
  assign w_offset   = d_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_offset} < c_SPAN);
  assign w_idx      = w_offset[c_AW+1:2];

  // --------------------------------------------------------------------------
  // FSM next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_accept_wr = 1'b0;
    w_enter_ack = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (d_wr_req || d_rd_req) begin
          // A write wins when both are high; the read stays on the bus
          // and is taken in a later IDLE cycle.
          w_accept    = 1'b1;
          w_accept_wr = d_wr_req;
          w_cnt_nxt   = c_WAIT;
          if (c_WAIT == 4'd0) begin
            w_state_nxt = ST_ACK;
            w_enter_ack = 1'b1;
          end else begin
            w_state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        w_cnt_nxt = r_cnt - 4'd1;
        // cnt was loaded with WAIT_CYCLES, so leaving at cnt==1 spends
        // exactly WAIT_CYCLES cycles here.
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_ACK;
          w_enter_ack = 1'b1;
        end
      end
      ST_ACK: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // With no wait states the ACK-entry edge is the acceptance edge, so the
  // read side must use the live decode instead of the latched copy.
  assign w_ack_rd       = (r_state == ST_IDLE) ? !d_wr_req  : !r_is_wr;
  assign w_ack_idx      = (r_state == ST_IDLE) ? w_idx      : r_idx;
  assign w_ack_in_range = (r_state == ST_IDLE) ? w_in_range : r_in_range;

  // --------------------------------------------------------------------------
  // FSM state register and read-data register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_is_wr    <= 1'b0;
      r_rd_data  <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx      <= w_idx;
        r_in_range <= w_in_range;
        r_is_wr    <= w_accept_wr;
      end
      if (w_enter_ack && w_ack_rd) begin
        r_rd_data <= w_ack_in_range ? r_mem[w_ack_idx] : 32'h0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Storage array: no reset, contents survive rst. Out-of-range writes are
  // dropped here but still complete on the bus.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst && w_accept_wr && w_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (d_be[i]) begin
          r_mem[w_idx][8*i +: 8] <= d_wr_data[8*i +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign d_rd_ready = (r_state == ST_ACK) && !r_is_wr;
  assign d_wr_ready = (r_state == ST_ACK) &&  r_is_wr;
  assign d_rd_data  = r_rd_data;

`ifdef DMEM_ERR_EN
  logic r_bus_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bus_err <= 1'b0;
    end else if (w_accept && !w_in_range) begin
      r_bus_err <= 1'b1;
    end
  end

  assign bus_err = r_bus_err;
`endif

endmodule

`default_nettype wire
